// File: rtl/pwm_cfg_loader_pkg.sv
// Shared definitions for the serial PWM configuration loader: FSM encoding,
// frame layout and the duty clamp used when decoding duty frames.
package pwm_cfg_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2,
      ST_WRITE = 2'd3
   } state_e;

   localparam int FRAME_BITS = 16;
   localparam int DUTY_MAX   = 100;
   localparam int SEL_BIT    = 15;
   localparam int DATA_MSB   = 11;
   localparam int DATA_LSB   = 0;
   localparam int DUTY_MSB   = 6;
   localparam int CFG_W      = 12;
   localparam int CNT_W      = 5;

   // Duty is a percentage; anything above DUTY_MAX is pinned to 100 %.
   function automatic logic [CFG_W-1:0] clamp_duty(input logic [DUTY_MSB:0] raw);
      if (int'(raw) > DUTY_MAX) return CFG_W'(DUTY_MAX);
      else                      return CFG_W'(raw);
   endfunction

endpackage

// File: rtl/pwm_cfg_loader_if.sv
// Serial frame inputs and the register-write port toward the PWM generator.
// cfg_wr_en is a one-cycle strobe; cfg_in/cfg_sel are valid while it is high
// and hold afterwards. There is no back-pressure: the consumer must take every strobe.
interface pwm_cfg_loader_if;
   import pwm_cfg_loader_pkg::*;

   logic             sclk;
   logic             sdi;
   logic             cs_n;
   logic [CFG_W-1:0] cfg_in;
   logic             cfg_sel;
   logic             cfg_wr_en;

   modport master (
      output sclk, sdi, cs_n,
      input  cfg_in, cfg_sel, cfg_wr_en
   );

   modport slave (
      input  sclk, sdi, cs_n,
      output cfg_in, cfg_sel, cfg_wr_en
   );

endinterface

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with registered
// rise/fall pulses taken from the synchronized level.
module pwm_sync_edge
   import pwm_cfg_loader_pkg::*;
#(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = din;
      for (int i = 1; i < STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      rise_d = sync_q[STAGES-1] & ~prev_q;
      fall_d = ~sync_q[STAGES-1] & prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= sync_q[STAGES-1];
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/pwm_cfg_loader.sv
// Receives 16-bit serial frames (MSB first) and turns valid ones into a single
// duty or period register write, raising sticky flags for rejected frames.
module pwm_cfg_loader #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = pwm_cfg_loader_pkg::FRAME_BITS
) (
   input  logic                       clk,
   input  logic                       rst_n,
   pwm_cfg_loader_if.slave            bus,
   input  logic                       err_clr,
   output logic                       busy,
   output logic                       frame_err,
   output logic                       range_err,
   output logic                       duty_sat,
   output pwm_cfg_loader_pkg::state_e dbg_state
);
   import pwm_cfg_loader_pkg::*;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

   logic sclk_rise, sdi_lvl, cs_rise, cs_fall;
   logic sclk_lvl_unused, sclk_fall_unused;
   logic sdi_rise_unused, sdi_fall_unused, cs_lvl_unused;

   pwm_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .din(bus.sclk),
      .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
   );

   pwm_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
      .clk(clk), .rst_n(rst_n), .din(bus.sdi),
      .level(sdi_lvl), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
   );

   // cs_n idles high, so its synchronizer resets high to avoid a false frame start.
   pwm_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .din(bus.cs_n),
      .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
   );

   state_e                state_q, state_d;
   logic [FRAME_BITS-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CFG_W-1:0]      cfg_in_q, cfg_in_d;
   logic                  cfg_sel_q, cfg_sel_d;
   logic                  wr_en_q, wr_en_d;
   logic                  busy_q, busy_d;
   logic                  ferr_q, ferr_d;
   logic                  rerr_q, rerr_d;
   logic                  dsat_q, dsat_d;

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      cfg_in_d  = cfg_in_q;
      cfg_sel_d = cfg_sel_q;
      wr_en_d   = 1'b0;
      // Clear first so a coincident set below takes priority.
      ferr_d    = ferr_q & ~err_clr;
      rerr_d    = rerr_q & ~err_clr;
      dsat_d    = dsat_q & ~err_clr;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d = ST_SHIFT;
               sr_d    = '0;
               cnt_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (sclk_rise) begin
               sr_d = {sr_q[FRAME_BITS-2:0], sdi_lvl};
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end
            if (cs_rise) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (cnt_q != CNT_FULL) begin
               ferr_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (sr_q[SEL_BIT]) begin
               if (sr_q[DATA_MSB:DATA_LSB] == '0) begin
                  rerr_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  cfg_in_d  = sr_q[DATA_MSB:DATA_LSB];
                  cfg_sel_d = 1'b1;
                  wr_en_d   = 1'b1;
                  state_d   = ST_WRITE;
               end
            end else begin
               cfg_in_d  = clamp_duty(sr_q[DUTY_MSB:0]);
               cfg_sel_d = 1'b0;
               wr_en_d   = 1'b1;
               state_d   = ST_WRITE;
               if (int'(sr_q[DUTY_MSB:0]) > DUTY_MAX) dsat_d = 1'b1;
            end
         end
         ST_WRITE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         sr_q      <= '0;
         cnt_q     <= '0;
         cfg_in_q  <= '0;
         cfg_sel_q <= 1'b0;
         wr_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         ferr_q    <= 1'b0;
         rerr_q    <= 1'b0;
         dsat_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         cfg_in_q  <= cfg_in_d;
         cfg_sel_q <= cfg_sel_d;
         wr_en_q   <= wr_en_d;
         busy_q    <= busy_d;
         ferr_q    <= ferr_d;
         rerr_q    <= rerr_d;
         dsat_q    <= dsat_d;
      end
   end

   assign bus.cfg_in    = cfg_in_q;
   assign bus.cfg_sel   = cfg_sel_q;
   assign bus.cfg_wr_en = wr_en_q;
   assign busy          = busy_q;
   assign frame_err     = ferr_q;
   assign range_err     = rerr_q;
   assign duty_sat      = dsat_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_pwm_cfg_loader.sv
// Scoreboarded bench for pwm_cfg_loader: directed and random serial frames
// drive two instances (SYNC_STAGES 2 and 3); monitors check writes and timing.
module tb_pwm_cfg_loader;
   import pwm_cfg_loader_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic err_clr;
   logic busy, frame_err, range_err, duty_sat;
   logic busy3, frame_err3, range_err3, duty_sat3;
   state_e dbg_state, dbg_state3;

   int checks   = 0;
   int failures = 0;

   pwm_cfg_loader_if bus ();
   pwm_cfg_loader_if bus3 ();

   assign bus3.sclk = bus.sclk;
   assign bus3.sdi  = bus.sdi;
   assign bus3.cs_n = bus.cs_n;

   pwm_cfg_loader #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .err_clr(err_clr),
      .busy(busy), .frame_err(frame_err), .range_err(range_err),
      .duty_sat(duty_sat), .dbg_state(dbg_state)
   );

   pwm_cfg_loader #(.SYNC_STAGES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3), .err_clr(err_clr),
      .busy(busy3), .frame_err(frame_err3), .range_err(range_err3),
      .duty_sat(duty_sat3), .dbg_state(dbg_state3)
   );

   // clock / reset
   always #10 clk = ~clk;

   initial begin
      #(20 * 90000);
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // reference model state
   logic [12:0] exp_q[$];
   logic [12:0] exp3_q[$];
   logic [11:0] last_cfg = '0;
   logic        last_sel = 1'b0;
   logic        exp_ferr = 1'b0, exp_rerr = 1'b0, exp_dsat = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // What a correct loader does with a finished frame of nbits bits.
   task automatic model_frame(input logic [31:0] val, input int nbits);
      int sel, data, duty;
      if (nbits != 16) begin
         exp_ferr = 1'b1;
      end else begin
         sel  = int'(val[15]);
         data = int'(val) % 4096;
         if (sel == 1) begin
            if (data == 0) exp_rerr = 1'b1;
            else begin
               last_cfg = 12'(data);
               last_sel = 1'b1;
               exp_q.push_back({1'b1, last_cfg});
               exp3_q.push_back({1'b1, last_cfg});
            end
         end else begin
            duty = data % 128;
            if (duty > 100) begin
               exp_dsat = 1'b1;
               duty = 100;
            end
            last_cfg = 12'(duty);
            last_sel = 1'b0;
            exp_q.push_back({1'b0, last_cfg});
            exp3_q.push_back({1'b0, last_cfg});
         end
      end
   endtask

   // monitors
   int   cyc = 0;
   int   rise_cyc = 0;
   logic cs_prev = 1'b1;
   logic wr_prev = 1'b0, wr3_prev = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (bus.cs_n && !cs_prev) rise_cyc = cyc;
      cs_prev = bus.cs_n;
   end

   always @(negedge clk) begin
      if (rst_n && bus.cfg_wr_en) begin
         chk("wr_single_cycle", {31'b0, wr_prev}, 0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wr_unexpected: got write 0x%0h expected no write", {bus.cfg_sel, bus.cfg_in});
         end else begin
            chk("wr_data", {19'b0, bus.cfg_sel, bus.cfg_in}, {19'b0, exp_q.pop_front()});
            chk("wr_latency_s2", cyc - rise_cyc, 4);
         end
      end
      wr_prev = bus.cfg_wr_en;
   end

   always @(negedge clk) begin
      if (rst_n && bus3.cfg_wr_en) begin
         chk("wr3_single_cycle", {31'b0, wr3_prev}, 0);
         if (exp3_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wr3_unexpected: got write 0x%0h expected no write", {bus3.cfg_sel, bus3.cfg_in});
         end else begin
            chk("wr3_data", {19'b0, bus3.cfg_sel, bus3.cfg_in}, {19'b0, exp3_q.pop_front()});
            chk("wr_latency_s3", cyc - rise_cyc, 5);
         end
      end
      wr3_prev = bus3.cfg_wr_en;
   end

   // driver tasks
   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_idle();
      chk("frame_err", {31'b0, frame_err}, {31'b0, exp_ferr});
      chk("range_err", {31'b0, range_err}, {31'b0, exp_rerr});
      chk("duty_sat",  {31'b0, duty_sat},  {31'b0, exp_dsat});
      chk("frame_err_s3", {31'b0, frame_err3}, {31'b0, exp_ferr});
      chk("busy_idle", {31'b0, busy}, 0);
      chk("cfg_in_hold", {20'b0, bus.cfg_in}, {20'b0, last_cfg});
      chk("cfg_sel_hold", {31'b0, bus.cfg_sel}, {31'b0, last_sel});
      chk("state_idle", {30'b0, dbg_state}, {30'b0, ST_IDLE});
   endtask

   task automatic sclk_noise();
      for (int k = 0; k < 2; k++) begin
         bus.sdi  = 1'($urandom_range(0, 1));
         bus.sclk = 1'b1;
         wait_cyc(4);
         bus.sclk = 1'b0;
         wait_cyc(4);
      end
      wait_cyc(6);
   endtask

   task automatic send_frame(input logic [31:0] val, input int nbits);
      bus.cs_n = 1'b0;
      wait_cyc(8);
      for (int b = nbits - 1; b >= 0; b--) begin
         bus.sdi  = val[b];
         bus.sclk = 1'b0;
         wait_cyc(4);
         bus.sclk = 1'b1;
         wait_cyc(4);
         if (b == nbits - 8) chk("busy_mid", {31'b0, busy}, 1);
      end
      bus.sclk = 1'b0;
      wait_cyc(4);
      model_frame(val, nbits);
      bus.cs_n = 1'b1;
      wait_cyc(12);
      check_idle();
      sclk_noise();
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      wait_cyc(1);
      err_clr = 1'b0;
      exp_ferr = 1'b0;
      exp_rerr = 1'b0;
      exp_dsat = 1'b0;
      wait_cyc(2);
      check_idle();
   endtask

   task automatic reset_mid_frame(input logic [31:0] val);
      bus.cs_n = 1'b0;
      wait_cyc(8);
      for (int b = 15; b >= 8; b--) begin
         bus.sdi  = val[b];
         bus.sclk = 1'b0;
         wait_cyc(4);
         bus.sclk = 1'b1;
         wait_cyc(4);
      end
      #3 rst_n = 1'b0;
      #1;
      chk("rst_cfg_in", {20'b0, bus.cfg_in}, 0);
      chk("rst_cfg_sel", {31'b0, bus.cfg_sel}, 0);
      chk("rst_wr_en", {31'b0, bus.cfg_wr_en}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_flags", {29'b0, frame_err, range_err, duty_sat}, 0);
      chk("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
      bus.cs_n = 1'b1;
      bus.sclk = 1'b0;
      last_cfg = '0;
      last_sel = 1'b0;
      exp_ferr = 1'b0;
      exp_rerr = 1'b0;
      exp_dsat = 1'b0;
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(10);
      check_idle();
   endtask

   // stimulus
   initial begin
      int r, nbits;
      logic [31:0] val;
      rst_n    = 1'b0;
      err_clr  = 1'b0;
      bus.sclk = 1'b0;
      bus.sdi  = 1'b0;
      bus.cs_n = 1'b1;
      wait_cyc(3);
      chk("reset_cfg_in", {20'b0, bus.cfg_in}, 0);
      chk("reset_wr_en", {31'b0, bus.cfg_wr_en}, 0);
      chk("reset_busy", {31'b0, busy}, 0);
      chk("reset_flags", {29'b0, frame_err, range_err, duty_sat}, 0);
      chk("reset_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
      rst_n = 1'b1;
      wait_cyc(5);

      send_frame(32'h8FA0, 16);
      send_frame(32'h0032, 16);
      send_frame(32'h007F, 16);
      pulse_err_clr();
      send_frame(32'h8000, 16);
      pulse_err_clr();
      send_frame(32'h0ABC, 15);
      pulse_err_clr();
      send_frame(32'h1_0064, 17);
      reset_mid_frame(32'h8064);
      send_frame(32'h8064, 16);

      for (int i = 0; i < 16; i++) begin
         r     = $urandom_range(0, 9);
         nbits = (r == 0) ? 15 : (r == 1) ? 17 : 16;
         val   = 32'($urandom_range(0, 131071));
         if (r == 2) val = 32'h8000 | (val & 32'h7000);
         if (r == 3) pulse_err_clr();
         send_frame(val, nbits);
      end

      for (int t = 0; t < 50 && (exp_q.size() != 0 || exp3_q.size() != 0); t++) wait_cyc(1);
      chk("queue_drain", exp_q.size(), 0);
      chk("queue3_drain", exp3_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
